// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter in front of a single uart_tx write port.
// A winner keeps the port until its last word is accepted or it stalls too long.
module uart_tx_arbiter #(
  parameter  int N_REQ      = 4,
  parameter  int BYTE_WIDTH = 1,
  parameter  int TIMEOUT    = 4096,
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int DW = BYTE_WIDTH * 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      s_wreq,
  input  logic [N_REQ-1:0]      s_wlast,
  input  logic [N_REQ*DW-1:0]   s_wdata,
  output logic [N_REQ-1:0]      s_wgnt,
  output logic                  m_wreq,
  input  logic                  m_wgnt,
  output logic [DW-1:0]         m_wdata,
  output logic                  busy,
  output logic [OW-1:0]         owner,
  output logic                  timeout_pulse
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  localparam int          TO_M1   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [15:0] TO_LAST = 16'(TO_M1);
  localparam logic        TO_EN   = (TIMEOUT > 0);

  logic [0:0]    r_state;
  logic [OW-1:0] r_owner;
  logic [OW-1:0] r_rr_ptr;
  logic [15:0]   r_stall_cnt;
  logic          r_timeout_pulse;

  logic          w_lock;
  logic          w_any;
  logic [OW-1:0] w_pick;
  logic [OW-1:0] w_next_ptr;
  logic          w_own_req;
  logic          w_own_last;
  logic          w_done;
  logic          w_stall;
  logic          w_expire;
  int            w_best;
  int            w_dist;

  assign w_lock = (r_state == ST_LOCK);

  // Winner is the requester with the smallest distance from rr_ptr
  always_comb begin
    w_any  = |s_wreq;
    w_pick = '0;
    w_best = N_REQ;
    w_dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = (i - int'(r_rr_ptr) + N_REQ) % N_REQ;
      if (s_wreq[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_pick = OW'(i);
      end
    end
  end

  always_comb begin
    m_wdata    = s_wdata[DW-1:0];
    w_own_req  = 1'b0;
    w_own_last = 1'b0;
    s_wgnt     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == OW'(i)) begin
        m_wdata    = s_wdata[i*DW +: DW];
        w_own_req  = s_wreq[i];
        w_own_last = s_wlast[i];
        s_wgnt[i]  = w_lock & m_wgnt;
      end
    end
  end

  assign w_next_ptr = (r_owner == OW'(N_REQ - 1)) ?
                      '0 : r_owner + OW'(1);

  assign m_wreq   = w_lock & w_own_req;
  assign w_done   = w_lock & m_wgnt & w_own_req & w_own_last;
  assign w_stall  = w_lock & ~w_own_req;
  assign w_expire = TO_EN & w_stall &
                    (r_stall_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_owner         <= '0;
      r_rr_ptr        <= '0;
      r_stall_cnt     <= '0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= 1'b0;
      unique case (1'b1)
        (r_state == ST_IDLE): begin
          if (w_any) begin
            r_owner     <= w_pick;
            r_state     <= ST_LOCK;
            r_stall_cnt <= '0;
          end
        end
        (r_state == ST_LOCK): begin
          // done needs the owner requesting, expire needs it idle
          if (w_done || w_expire) begin
            r_state         <= ST_IDLE;
            r_rr_ptr        <= w_next_ptr;
            r_stall_cnt     <= '0;
            r_timeout_pulse <= w_expire;
          end else if (w_own_req) begin
            r_stall_cnt <= '0;
          end else if (r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = w_lock;
  assign owner         = r_owner;
  assign timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand sequences
// for reset/back-pressure/timeout, and a 3-requester random scoreboard.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s_wreq;
  logic [3:0]  s_wlast;
  logic [31:0] s_wdata;
  logic [3:0]  s_wgnt;
  logic        m_wreq;
  logic        m_wgnt;
  logic [7:0]  m_wdata;
  logic        busy;
  logic [1:0]  owner;
  logic        timeout_pulse;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(4),
    .BYTE_WIDTH(1),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_wreq(s_wreq),
    .s_wlast(s_wlast),
    .s_wdata(s_wdata),
    .s_wgnt(s_wgnt),
    .m_wreq(m_wreq),
    .m_wgnt(m_wgnt),
    .m_wdata(m_wdata),
    .busy(busy),
    .owner(owner),
    .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  wreq;
    logic [3:0]  wlast;
    logic [31:0] wdata;
    logic        wgnt;
    logic [3:0]  gnt;
    logic        mreq;
    logic        busy;
    logic [1:0]  own;
    logic        tp;
    logic [7:0]  mdata;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    logic r, logic [3:0] rq, logic [3:0] ls,
    logic [31:0] d, logic g, logic [3:0] gn,
    logic mr, logic b, logic [1:0] o,
    logic t, logic [7:0] md);
    vec_t v;
    v.rst = r; v.wreq = rq; v.wlast = ls;
    v.wdata = d; v.wgnt = g; v.gnt = gn;
    v.mreq = mr; v.busy = b; v.own = o;
    v.tp = t; v.mdata = md;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq,
                       input logic [3:0] ls,
                       input logic [31:0] d, input logic g);
    rst = r; s_wreq = rq; s_wlast = ls;
    s_wdata = d; m_wgnt = g;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // random-phase state
  int          rem[3];
  int          gap[3];
  bit          pend[3];
  logic [5:0]  tx_seq[3];
  logic [5:0]  rx_seq[3];
  bit          msg_open;
  int          msg_j;
  bit          gen_en;
  int          grants;
  int          pulses;
  int          bad;
  int          gj;
  bit          all_idle;
  logic [16:0] act;
  logic [16:0] exv;

  initial begin
    drive(1'b1, 4'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // reset state, then message locking, then round-robin
    vt.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 0, 2'd0, 0, 8'h00));
    vt.push_back(mk(0, 4'b0001, 4'b0000, 32'h00000041, 0, 4'b0000, 0, 0, 2'd0, 0, 8'h00));
    vt.push_back(mk(0, 4'b0011, 4'b0000, 32'h00006141, 1, 4'b0001, 1, 1, 2'd0, 0, 8'h41));
    vt.push_back(mk(0, 4'b0011, 4'b0000, 32'h00006142, 1, 4'b0001, 1, 1, 2'd0, 0, 8'h42));
    vt.push_back(mk(0, 4'b0011, 4'b0001, 32'h00006143, 1, 4'b0001, 1, 1, 2'd0, 0, 8'h43));
    vt.push_back(mk(0, 4'b0010, 4'b0010, 32'h00006100, 0, 4'b0000, 0, 0, 2'd0, 0, 8'h00));
    vt.push_back(mk(0, 4'b0010, 4'b0010, 32'h00006100, 1, 4'b0010, 1, 1, 2'd1, 0, 8'h61));
    vt.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 0, 2'd1, 0, 8'h00));
    vt.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 0, 2'd1, 0, 8'h00));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0000, 0, 0, 2'd0, 0, 8'h00));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 1, 4'b0001, 1, 1, 2'd0, 0, 8'h11));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0000, 0, 0, 2'd0, 0, 8'h00));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 1, 4'b0010, 1, 1, 2'd1, 0, 8'h22));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0000, 0, 0, 2'd1, 0, 8'h00));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 1, 4'b0100, 1, 1, 2'd2, 0, 8'h33));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0000, 0, 0, 2'd2, 0, 8'h00));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 1, 4'b1000, 1, 1, 2'd3, 0, 8'h44));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 0, 4'b0000, 0, 0, 2'd3, 0, 8'h00));
    vt.push_back(mk(0, 4'b1111, 4'b1111, 32'h44332211, 1, 4'b0001, 1, 1, 2'd0, 0, 8'h11));
    vt.push_back(mk(0, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 0, 2'd0, 0, 8'h00));

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].wreq, vt[i].wlast,
            vt[i].wdata, vt[i].wgnt);
      @(negedge clk);
      act = {s_wgnt, m_wreq, busy, owner, timeout_pulse,
             (vt[i].mreq ? m_wdata : 8'h00)};
      exv = {vt[i].gnt, vt[i].mreq, vt[i].busy, vt[i].own,
             vt[i].tp, vt[i].mdata};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exv));
      nxt();
    end

    // reset mid-message: owner 1 after 2 of 5 words
    drive(0, 4'b0010, 4'b0000, 32'h0000A100, 0);
    @(negedge clk);
    chk("t5_idle", 64'(busy), 64'(0));
    nxt();
    drive(0, 4'b0010, 4'b0000, 32'h0000A100, 1);
    @(negedge clk);
    chk("t5_w1", 64'({s_wgnt, busy, owner, m_wdata}),
        64'({4'b0010, 1'b1, 2'd1, 8'hA1}));
    nxt();
    drive(0, 4'b0010, 4'b0000, 32'h0000A200, 1);
    @(negedge clk);
    chk("t5_w2", 64'({s_wgnt, busy, owner, m_wdata}),
        64'({4'b0010, 1'b1, 2'd1, 8'hA2}));
    nxt();
    drive(1, 4'b0010, 4'b0000, 32'h0000A300, 0);
    @(negedge clk);
    chk("t5_rst_cyc", 64'({busy, owner}), 64'({1'b1, 2'd1}));
    nxt();
    drive(0, 4'b1001, 4'b1001, 32'hD00000B0, 0);
    @(negedge clk);
    chk("t5_after_rst",
        64'({s_wgnt, m_wreq, busy, owner, timeout_pulse}), 64'(0));
    nxt();
    drive(0, 4'b1001, 4'b1001, 32'hD00000B0, 1);
    @(negedge clk);
    chk("t5_rr_reset", 64'({s_wgnt, busy, owner, m_wdata}),
        64'({4'b0001, 1'b1, 2'd0, 8'hB0}));
    nxt();
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    @(negedge clk);
    nxt();

    // downstream full for 10000 cycles with owner 2 requesting
    drive(0, 4'b0100, 4'b0000, 32'h00C20000, 0);
    @(negedge clk);
    chk("t3_arb", 64'(busy), 64'(0));
    nxt();
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      drive(0, 4'b0100, 4'b0000, 32'h00C20000, 0);
      @(negedge clk);
      if (!busy || timeout_pulse || owner != 2'd2 || s_wgnt != 4'b0)
        bad++;
      nxt();
    end
    chk("t3_full_hold", 64'(bad), 64'(0));
    drive(0, 4'b0100, 4'b0000, 32'h00C20000, 1);
    @(negedge clk);
    chk("t3_deliver", 64'({s_wgnt, m_wreq, m_wdata}),
        64'({4'b0100, 1'b1, 8'hC2}));
    nxt();

    // owner 2 abandons the message: 16 stall cycles then the pulse
    for (int k = 1; k <= 17; k++) begin
      drive(0, 4'b0000, 4'b0000, 32'h0, 0);
      @(negedge clk);
      chk($sformatf("t4_stall%0d", k),
          64'({busy, timeout_pulse}),
          64'({(k < 17), (k == 17)}));
      nxt();
    end
    drive(0, 4'b1111, 4'b1111, 32'h44332211, 0);
    @(negedge clk);
    chk("t4_pulse_end", 64'({busy, timeout_pulse}), 64'(0));
    nxt();
    drive(0, 4'b1111, 4'b1111, 32'h44332211, 1);
    @(negedge clk);
    chk("t4_rr_next", 64'({s_wgnt, owner, m_wdata}),
        64'({4'b1000, 2'd3, 8'h44}));
    nxt();
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    @(negedge clk);
    nxt();

    // random stress on requesters 0..2
    for (int j = 0; j < 3; j++) begin
      rem[j] = 0; gap[j] = 0; pend[j] = 0;
      tx_seq[j] = '0; rx_seq[j] = '0;
    end
    msg_open = 0; msg_j = 0;
    grants = 0; pulses = 0; all_idle = 0;
    for (int c = 0; c < 4000; c++) begin
      gen_en = (c < 3000);
      s_wreq = '0; s_wlast = '0; s_wdata = '0;
      for (int j = 0; j < 3; j++) begin
        if (!pend[j]) begin
          if (gap[j] > 0) gap[j]--;
          else if (rem[j] > 0) pend[j] = 1;
          else if (gen_en && $urandom_range(0, 3) == 0) begin
            rem[j]  = $urandom_range(1, 4);
            pend[j] = 1;
          end
        end
        s_wreq[j]  = pend[j];
        s_wlast[j] = pend[j] ? (rem[j] == 1) :
                     1'($urandom_range(0, 1));
        s_wdata[j*8 +: 8] = {2'(j), tx_seq[j]};
      end
      #1;
      m_wgnt = m_wreq & ($urandom_range(0, 2) != 0);
      @(negedge clk);
      chk("rnd_gnt_shape",
          64'(($countones(s_wgnt) <= 1) &&
              ((s_wgnt != 4'b0) == m_wgnt)), 64'(1));
      if (m_wgnt && s_wgnt != 4'b0) begin
        gj = 0;
        for (int i = 0; i < 4; i++) if (s_wgnt[i]) gj = i;
        chk("rnd_contig", 64'(msg_open ? msg_j : gj), 64'(gj));
        chk("rnd_req_valid", 64'((gj < 3) && pend[gj]), 64'(1));
        if (gj < 3 && pend[gj]) begin
          chk("rnd_data", 64'(m_wdata), 64'({2'(gj), rx_seq[gj]}));
          rx_seq[gj]++;
          msg_open = !s_wlast[gj];
          msg_j    = gj;
          pend[gj] = 0;
          rem[gj]--;
          tx_seq[gj]++;
          gap[gj]  = $urandom_range(0, 2);
          grants++;
        end
      end
      if (timeout_pulse) pulses++;
      nxt();
      all_idle = 1;
      for (int j = 0; j < 3; j++)
        if (pend[j] || rem[j] != 0) all_idle = 0;
      if (!gen_en && all_idle) break;
    end
    drive(0, 4'b0000, 4'b0000, 32'h0, 0);
    chk("rnd_drained", 64'(all_idle), 64'(1));
    chk("rnd_no_timeout", 64'(pulses), 64'(0));
    chk("rnd_progress", 64'(grants > 200), 64'(1));
    chk("rnd_no_open_msg", 64'(msg_open), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
